dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / debug) arbiter for a single-port data memory with 1-cycle read latency.
// Optional CPU stall-cycle counter enabled by defining DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_be,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    output logic [DATA_W-1:0]     cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [DATA_W/8-1:0]   dbg_be,
    output logic                  dbg_ack,
    output logic [DATA_W-1:0]     dbg_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic [15:0]           cpu_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RSP = 2'd1,
        DBG_RSP = 2'd2
    } stateT;

    stateT state;
    stateT nextState;
    logic  lastDbg;
    logic  grantCpu;
    logic  grantDbg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // lastDbg=1 means debug was granted most recently, so the CPU wins the next tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastDbg <= 1'b1;
        end else if (grantCpu) begin
            lastDbg <= 1'b0;
        end else if (grantDbg) begin
            lastDbg <= 1'b1;
        end
    end

    // A requester in its own ack cycle is never re-issued; only the other side can be.
    always_comb begin
        grantCpu  = 1'b0;
        grantDbg  = 1'b0;
        nextState = IDLE;
        case (state)
            IDLE: begin
                if (cpu_req && (!dbg_req || lastDbg)) begin
                    grantCpu = 1'b1;
                end else if (dbg_req) begin
                    grantDbg = 1'b1;
                end
            end
            CPU_RSP: grantDbg = dbg_req;
            DBG_RSP: grantCpu = cpu_req;
            default: ;
        endcase
        if (!reset) begin
            grantCpu = 1'b0;
            grantDbg = 1'b0;
        end
        if (grantCpu) begin
            nextState = CPU_RSP;
        end else if (grantDbg) begin
            nextState = DBG_RSP;
        end
    end

    always_comb begin
        mem_en    = grantCpu | grantDbg;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (grantCpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end else if (grantDbg) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_be    = dbg_be;
        end
        cpu_ack   = (state == CPU_RSP);
        dbg_ack   = (state == DBG_RSP);
        cpu_rdata = cpu_ack ? mem_rdata : '0;
        dbg_rdata = dbg_ack ? mem_rdata : '0;
        cpu_stall = cpu_req & ~cpu_ack;
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] waitCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (cpu_stall && (waitCnt != 16'hFFFF)) begin
            waitCnt <= waitCnt + 16'd1;
        end
    end

    assign cpu_wait_cnt = waitCnt;
`else
    assign cpu_wait_cnt = '0;
`endif

endmodule
